// File: rtl/sram_uart_pkg.sv
// Shared types and constants for the SRAM/UART exerciser.
// Optional feature macro used by the top: SRAM_VERIFY_EN.
package sram_uart_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    // SRAM strobes are active-low; OFF is the idle/reset level.
    localparam logic STROBE_OFF = 1'b1;
    localparam logic STROBE_ON  = 1'b0;

    // Byte sent instead of the readback when verification fails.
    localparam logic [7:0] VERIFY_ERR_BYTE = 8'h21;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_PULSE,
        ST_RD_SAMPLE,
        ST_TX_WAIT
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/sram_uart_rx.sv
// 8N1 UART receiver with 2-FF input synchroniser.
// Emits a one-cycle valid_o with data_o when a frame has a good stop bit.
module sram_uart_rx
    import sram_uart_pkg::*;
#(
    parameter int BAUD_DIV = 100
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       valid_o,
    output logic [7:0] data_o
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

    logic             s1_q, s2_q, s3_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;

    // Synchroniser plus one delayed copy for falling-edge detection (idle high).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= rx_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    // Mid-bit sampling: half a bit to re-check start, then full bits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (s3_q && !s2_q) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {s2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = s2_q;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign valid_o = valid_q;
    assign data_o  = shift_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: tx_ready while idle, byte latched on tx_req & tx_ready.
// Active-low asynchronous reset (reset_).
module uart_tx #(
    parameter int BAUD_DIV = 100
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       tx_req,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       uart_tx
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [9:0]       shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bits_q, bits_d;
    logic             busy_q, busy_d;

    // Transmit state registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            shift_q <= '1;
            cnt_q   <= '0;
            bits_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            busy_q  <= busy_d;
        end
    end

    // Frame sequencing: start, 8 data bits LSB first, stop.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        busy_d  = busy_q;
        if (!busy_q) begin
            if (tx_req) begin
                shift_d = {1'b1, tx_data, 1'b0};
                cnt_d   = '0;
                bits_d  = '0;
                busy_d  = 1'b1;
            end
        end else if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            shift_d = {1'b1, shift_q[9:1]};
            if (bits_q == 4'd9) begin
                busy_d = 1'b0;
            end else begin
                bits_d = bits_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tx_ready = !busy_q;
    assign uart_tx  = busy_q ? shift_q[0] : 1'b1;

endmodule

// File: rtl/sram_uart_chip.sv
// SRAM exerciser top: each received UART byte is written to the next SRAM
// word, read back and echoed over UART. B1 (active-low) dumps all stored bytes.
// Optional macro SRAM_VERIFY_EN: echo 0x21 when readback differs from the write.
module sram_uart_chip
    import sram_uart_pkg::*;
#(
    parameter int BAUD_DIV = 100,
    parameter int RAM_WAIT = 2
) (
    input  logic              clk,
    input  logic              greset,
    input  logic              B1,
    input  logic              UART_RX,
    output logic              UART_TX,
    output logic              RAMCS,
    output logic              RAMWE,
    output logic              RAMOE,
    output logic              RAMLB,
    output logic              RAMUB,
    output logic [ADDR_W-1:0] ADR,
    inout  wire  [DATA_W-1:0] DAT
);

    localparam logic [7:0] WAIT_LAST = 8'(RAM_WAIT - 1);

    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_req, tx_ready;

    logic              b1_s1_q, b1_s2_q, b1_prev_q;
    logic              b1_fall;

    state_e            state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]        wait_q, wait_d;
    logic              dump_q, dump_d;

    logic              cs_n, we_n, oe_n, lb_n, dat_oe;
    logic              unused_dat_hi;

    sram_uart_rx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk_i  (clk),
        .rst_i  (greset),
        .rx_i   (UART_RX),
        .valid_o(rx_valid),
        .data_o (rx_data)
    );

    uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx (
        .clk     (clk),
        .reset_  (~greset),
        .tx_req  (tx_req),
        .tx_ready(tx_ready),
        .tx_data (tx_q),
        .uart_tx (UART_TX)
    );

    // B1 synchroniser with a delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            b1_s1_q   <= 1'b1;
            b1_s2_q   <= 1'b1;
            b1_prev_q <= 1'b1;
        end else begin
            b1_s1_q   <= B1;
            b1_s2_q   <= b1_s1_q;
            b1_prev_q <= b1_s2_q;
        end
    end

    assign b1_fall = b1_prev_q && !b1_s2_q;

    // Access sequencer state registers.
    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            state_q  <= ST_IDLE;
            byte_q   <= '0;
            tx_q     <= '0;
            adr_q    <= '0;
            wr_ptr_q <= '0;
            wait_q   <= '0;
            dump_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
            adr_q    <= adr_d;
            wr_ptr_q <= wr_ptr_d;
            wait_q   <= wait_d;
            dump_q   <= dump_d;
        end
    end

    // Next-state and SRAM strobe decode; strobes depend only on state so an
    // asynchronous reset returns the bus to idle immediately.
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        tx_d     = tx_q;
        adr_d    = adr_q;
        wr_ptr_d = wr_ptr_q;
        wait_d   = wait_q;
        dump_d   = dump_q;
        cs_n     = STROBE_OFF;
        we_n     = STROBE_OFF;
        oe_n     = STROBE_OFF;
        lb_n     = STROBE_OFF;
        dat_oe   = 1'b0;
        tx_req   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (rx_valid) begin
                    byte_d  = rx_data;
                    adr_d   = wr_ptr_q;
                    state_d = ST_WR_SETUP;
                end else if (b1_fall && (wr_ptr_q != '0)) begin
                    dump_d  = 1'b1;
                    adr_d   = '0;
                    state_d = ST_RD_PULSE;
                end
            end
            ST_WR_SETUP: begin
                cs_n    = STROBE_ON;
                lb_n    = STROBE_ON;
                dat_oe  = 1'b1;
                wait_d  = '0;
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                cs_n   = STROBE_ON;
                lb_n   = STROBE_ON;
                we_n   = STROBE_ON;
                dat_oe = 1'b1;
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_WR_HOLD;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_WR_HOLD: begin
                cs_n    = STROBE_ON;
                lb_n    = STROBE_ON;
                dat_oe  = 1'b1;
                wait_d  = '0;
                state_d = ST_RD_PULSE;
            end
            ST_RD_PULSE: begin
                cs_n = STROBE_ON;
                oe_n = STROBE_ON;
                lb_n = STROBE_ON;
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = ST_RD_SAMPLE;
`ifdef SRAM_VERIFY_EN
                    if (!dump_q && (DAT[7:0] != byte_q)) begin
                        tx_d = VERIFY_ERR_BYTE;
                    end else begin
                        tx_d = DAT[7:0];
                    end
`else
                    tx_d = DAT[7:0];
`endif
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_RD_SAMPLE: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                tx_req = 1'b1;
                if (tx_ready) begin
                    if (dump_q) begin
                        if (adr_q == wr_ptr_q - ADDR_W'(1)) begin
                            dump_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            adr_d   = adr_q + ADDR_W'(1);
                            state_d = ST_RD_PULSE;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign RAMCS = cs_n;
    assign RAMWE = we_n;
    assign RAMOE = oe_n;
    assign RAMLB = lb_n;
    assign RAMUB = STROBE_OFF;
    assign ADR   = adr_q;
    assign DAT   = dat_oe ? {8'h00, byte_q} : {DATA_W{1'bz}};

    assign unused_dat_hi = ^DAT[DATA_W-1:8];

endmodule

// File: tb/tb_sram_uart_chip.sv
module tb_sram_uart_chip;

    localparam int BAUD_DIV = 100;
    localparam int RAM_WAIT = 2;

    typedef struct {
        logic [17:0] adr;
        logic [15:0] dat;
        int unsigned len;
    } wr_t;

    logic        clk;
    logic        greset;
    logic        B1;
    logic        UART_RX;
    logic        UART_TX;
    logic        RAMCS, RAMWE, RAMOE, RAMLB, RAMUB;
    logic [17:0] ADR;
    wire  [15:0] DAT;
    logic        probe_en;

    int n_checks = 0;
    int n_fail   = 0;
    int viol     = 0;

    wr_t         exp_wr[$], got_wr[$];
    logic [17:0] exp_rd[$], got_rd[$];
    logic [7:0]  exp_tx[$], got_tx[$];

    // SRAM model returns the address as read data; probe driver detects contention.
    assign DAT = (!RAMCS && !RAMOE) ? ADR[15:0] : 16'hzzzz;
    assign DAT = probe_en ? 16'hA5A5 : 16'hzzzz;

    sram_uart_chip #(
        .BAUD_DIV(BAUD_DIV),
        .RAM_WAIT(RAM_WAIT)
    ) dut (
        .clk    (clk),
        .greset (greset),
        .B1     (B1),
        .UART_RX(UART_RX),
        .UART_TX(UART_TX),
        .RAMCS  (RAMCS),
        .RAMWE  (RAMWE),
        .RAMOE  (RAMOE),
        .RAMLB  (RAMLB),
        .RAMUB  (RAMUB),
        .ADR    (ADR),
        .DAT    (DAT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_rb(input logic [7:0] wr, input logic [17:0] adr,
                                          input bit dump);
`ifdef SRAM_VERIFY_EN
        if (!dump && (adr[7:0] != wr)) return 8'h21;
`endif
        return adr[7:0];
    endfunction

    // SRAM bus monitor: records completed write/read pulses and WE/OE overlap.
    initial begin : bus_mon
        int unsigned we_cnt;
        int unsigned oe_cnt;
        wr_t         w;
        logic [17:0] r_adr;
        we_cnt = 0;
        oe_cnt = 0;
        r_adr  = '0;
        w.adr  = '0;
        w.dat  = '0;
        w.len  = 0;
        forever begin
            @(negedge clk);
            if (!RAMWE && !RAMOE) viol++;
            if (!RAMCS && !RAMWE) begin
                we_cnt++;
                w.adr = ADR;
                w.dat = DAT;
                w.len = we_cnt;
            end else if (we_cnt != 0) begin
                got_wr.push_back(w);
                we_cnt = 0;
            end
            if (!RAMCS && !RAMOE) begin
                oe_cnt++;
                r_adr = ADR;
            end else if (oe_cnt != 0) begin
                got_rd.push_back(r_adr);
                oe_cnt = 0;
            end
        end
    end

    // UART line monitor: decodes DUT transmit frames.
    initial begin : tx_mon
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (UART_TX == 1'b0) begin
                repeat (BAUD_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD_DIV) @(negedge clk);
                    b[i] = UART_TX;
                end
                repeat (BAUD_DIV) @(negedge clk);
                got_tx.push_back(b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        UART_RX = 1'b0;
        repeat (BAUD_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (BAUD_DIV) @(negedge clk);
        end
        UART_RX = stop;
        repeat (BAUD_DIV) @(negedge clk);
        UART_RX = 1'b1;
    endtask

    task automatic flush_queues();
        exp_wr.delete(); got_wr.delete();
        exp_rd.delete(); got_rd.delete();
        exp_tx.delete(); got_tx.delete();
    endtask

    task automatic apply_reset();
        greset = 1'b1;
        repeat (3) @(negedge clk);
        greset = 1'b0;
        repeat (3) @(negedge clk);
        flush_queues();
    endtask

    task automatic pulse_b1();
        @(negedge clk);
        B1 = 1'b0;
        repeat (5) @(negedge clk);
        B1 = 1'b1;
    endtask

    // Waits (bounded) until every expected output has been observed, then settles.
    task automatic wait_outputs(output bit timed_out);
        int unsigned n;
        n = 0;
        while ((got_wr.size() < exp_wr.size() || got_rd.size() < exp_rd.size() ||
                got_tx.size() < exp_tx.size()) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= 8000);
        repeat (300) @(negedge clk);
    endtask

    task automatic test_reset();
        greset   = 1'b1;
        probe_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({RAMCS, RAMWE, RAMOE, RAMLB, RAMUB, UART_TX} !== 6'b111111) begin
                n_fail++;
                $display("FAIL reset_strobes cycle %0d: got %b, expected 111111", c,
                         {RAMCS, RAMWE, RAMOE, RAMLB, RAMUB, UART_TX});
            end
            n_checks++;
            if (DAT !== 16'hA5A5 || ADR !== 18'h0) begin
                n_fail++;
                $display("FAIL reset_bus cycle %0d: got DAT=%h ADR=%h, expected DAT=a5a5 (undriven) ADR=0",
                         c, DAT, ADR);
            end
        end
        probe_en = 1'b0;
        greset   = 1'b0;
        repeat (3) @(negedge clk);
        flush_queues();
    endtask

    task automatic test_single_byte();
        bit  to;
        wr_t e, g;
        e.adr = 18'h0; e.dat = 16'h0048; e.len = RAM_WAIT;
        exp_wr.push_back(e);
        exp_rd.push_back(18'h0);
        exp_tx.push_back(exp_rb(8'h48, 18'h0, 1'b0));
        send_byte(8'h48, 1'b1);
        wait_outputs(to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL single_timeout: got wr=%0d rd=%0d tx=%0d, expected wr=%0d rd=%0d tx=%0d",
                     got_wr.size(), got_rd.size(), got_tx.size(), exp_wr.size(), exp_rd.size(), exp_tx.size());
        end
        while (exp_wr.size() != 0 && got_wr.size() != 0) begin
            e = exp_wr.pop_front(); g = got_wr.pop_front();
            n_checks++;
            if (g.adr !== e.adr || g.dat !== e.dat || g.len !== e.len) begin
                n_fail++;
                $display("FAIL single_write: got adr=%h dat=%h len=%0d, expected adr=%h dat=%h len=%0d",
                         g.adr, g.dat, g.len, e.adr, e.dat, e.len);
            end
        end
        while (exp_rd.size() != 0 && got_rd.size() != 0) begin
            logic [17:0] ea, ga;
            ea = exp_rd.pop_front(); ga = got_rd.pop_front();
            n_checks++;
            if (ga !== ea) begin
                n_fail++;
                $display("FAIL single_read: got adr=%h, expected adr=%h", ga, ea);
            end
        end
        while (exp_tx.size() != 0 && got_tx.size() != 0) begin
            logic [7:0] eb, gb;
            eb = exp_tx.pop_front(); gb = got_tx.pop_front();
            n_checks++;
            if (gb !== eb) begin
                n_fail++;
                $display("FAIL single_tx: got %h, expected %h", gb, eb);
            end
        end
        n_checks++;
        if (got_wr.size() + got_rd.size() + got_tx.size() != 0) begin
            n_fail++;
            $display("FAIL single_extra: got %0d extra events, expected 0",
                     got_wr.size() + got_rd.size() + got_tx.size());
        end
        flush_queues();
    endtask

    task automatic test_back_to_back();
        bit         to;
        wr_t        e, g;
        logic [7:0] bytes[2];
        bytes[0] = 8'h48;
        bytes[1] = 8'h65;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            e.adr = 18'(i); e.dat = {8'h00, bytes[i]}; e.len = RAM_WAIT;
            exp_wr.push_back(e);
            exp_rd.push_back(18'(i));
            exp_tx.push_back(exp_rb(bytes[i], 18'(i), 1'b0));
        end
        send_byte(bytes[0], 1'b1);
        send_byte(bytes[1], 1'b1);
        wait_outputs(to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL b2b_timeout: got wr=%0d rd=%0d tx=%0d, expected wr=%0d rd=%0d tx=%0d",
                     got_wr.size(), got_rd.size(), got_tx.size(), exp_wr.size(), exp_rd.size(), exp_tx.size());
        end
        while (exp_wr.size() != 0 && got_wr.size() != 0) begin
            e = exp_wr.pop_front(); g = got_wr.pop_front();
            n_checks++;
            if (g.adr !== e.adr || g.dat !== e.dat || g.len !== e.len) begin
                n_fail++;
                $display("FAIL b2b_write: got adr=%h dat=%h len=%0d, expected adr=%h dat=%h len=%0d",
                         g.adr, g.dat, g.len, e.adr, e.dat, e.len);
            end
        end
        while (exp_rd.size() != 0 && got_rd.size() != 0) begin
            logic [17:0] ea, ga;
            ea = exp_rd.pop_front(); ga = got_rd.pop_front();
            n_checks++;
            if (ga !== ea) begin
                n_fail++;
                $display("FAIL b2b_read: got adr=%h, expected adr=%h", ga, ea);
            end
        end
        while (exp_tx.size() != 0 && got_tx.size() != 0) begin
            logic [7:0] eb, gb;
            eb = exp_tx.pop_front(); gb = got_tx.pop_front();
            n_checks++;
            if (gb !== eb) begin
                n_fail++;
                $display("FAIL b2b_tx: got %h, expected %h", gb, eb);
            end
        end
        n_checks++;
        if (got_wr.size() + got_rd.size() + got_tx.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_extra: got %0d extra events, expected 0",
                     got_wr.size() + got_rd.size() + got_tx.size());
        end
        flush_queues();
    endtask

    // Relies on the two bytes stored by test_back_to_back (write pointer = 2).
    task automatic test_dump();
        bit to;
        for (int i = 0; i < 2; i++) begin
            exp_rd.push_back(18'(i));
            exp_tx.push_back(exp_rb(8'h00, 18'(i), 1'b1));
        end
        pulse_b1();
        wait_outputs(to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL dump_timeout: got rd=%0d tx=%0d, expected rd=%0d tx=%0d",
                     got_rd.size(), got_tx.size(), exp_rd.size(), exp_tx.size());
        end
        while (exp_rd.size() != 0 && got_rd.size() != 0) begin
            logic [17:0] ea, ga;
            ea = exp_rd.pop_front(); ga = got_rd.pop_front();
            n_checks++;
            if (ga !== ea) begin
                n_fail++;
                $display("FAIL dump_read: got adr=%h, expected adr=%h", ga, ea);
            end
        end
        while (exp_tx.size() != 0 && got_tx.size() != 0) begin
            logic [7:0] eb, gb;
            eb = exp_tx.pop_front(); gb = got_tx.pop_front();
            n_checks++;
            if (gb !== eb) begin
                n_fail++;
                $display("FAIL dump_tx: got %h, expected %h", gb, eb);
            end
        end
        n_checks++;
        if (got_wr.size() + got_rd.size() + got_tx.size() != 0) begin
            n_fail++;
            $display("FAIL dump_extra: got %0d extra events (wr=%0d), expected 0",
                     got_wr.size() + got_rd.size() + got_tx.size(), got_wr.size());
        end
        flush_queues();
    endtask

    task automatic test_dump_empty();
        apply_reset();
        pulse_b1();
        repeat (3000) @(negedge clk);
        n_checks++;
        if (got_wr.size() + got_rd.size() + got_tx.size() != 0) begin
            n_fail++;
            $display("FAIL dump_empty: got wr=%0d rd=%0d tx=%0d, expected none",
                     got_wr.size(), got_rd.size(), got_tx.size());
        end
        flush_queues();
    endtask

    task automatic test_bad_stop();
        wr_t g;
        send_byte(8'h5A, 1'b0);
        repeat (2000) @(negedge clk);
        n_checks++;
        if (got_wr.size() + got_rd.size() + got_tx.size() != 0) begin
            n_fail++;
            $display("FAIL bad_stop: got wr=%0d rd=%0d tx=%0d, expected none",
                     got_wr.size(), got_rd.size(), got_tx.size());
        end
        flush_queues();
        send_byte(8'h3C, 1'b1);
        repeat (200) @(negedge clk);
        n_checks++;
        if (got_wr.size() != 1) begin
            n_fail++;
            $display("FAIL bad_stop_recover_count: got %0d writes, expected 1", got_wr.size());
        end else begin
            g = got_wr.pop_front();
            n_checks++;
            if (g.adr !== 18'h0 || g.dat !== 16'h003C) begin
                n_fail++;
                $display("FAIL bad_stop_recover: got adr=%h dat=%h, expected adr=0 dat=003c", g.adr, g.dat);
            end
        end
        repeat (1500) @(negedge clk);
        flush_queues();
    endtask

    task automatic test_reset_mid_write();
        int unsigned n;
        apply_reset();
        fork
            send_byte(8'h48, 1'b1);
        join_none
        n = 0;
        while (RAMWE && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (RAMWE !== 1'b0) begin
            n_fail++;
            $display("FAIL midwr_timeout: got RAMWE=%b, expected 0 within 3000 cycles", RAMWE);
        end
        greset   = 1'b1;
        probe_en = 1'b1;
        #1;
        n_checks++;
        if (RAMWE !== 1'b1 || RAMCS !== 1'b1) begin
            n_fail++;
            $display("FAIL midwr_strobes: got WE=%b CS=%b, expected 1 1", RAMWE, RAMCS);
        end
        n_checks++;
        if (DAT !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL midwr_dat: got %h, expected a5a5 (DUT not driving)", DAT);
        end
        repeat (3) @(negedge clk);
        probe_en = 1'b0;
        greset   = 1'b0;
        repeat (1200) @(negedge clk);
        flush_queues();
    endtask

    task automatic test_bus_safety();
        n_checks++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL bus_safety: got %0d cycles with WE and OE low, expected 0", viol);
        end
    endtask

    initial begin
        greset   = 1'b1;
        B1       = 1'b1;
        UART_RX  = 1'b1;
        probe_en = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_dump();
        test_dump_empty();
        test_bad_stop();
        test_reset_mid_write();
        test_bus_safety();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_uart_chip.md
Name: sram_uart_chip

Overview:
Top-level SRAM exerciser for the board. Receives 8N1 UART bytes and writes each one to external 256Kx16 async SRAM at an incrementing address. Reads the same location back and transmits the readback byte over UART. Button B1 (active-low) dumps all stored bytes.

Parameters:
BAUD_DIV, 100, clk cycles per UART bit (1 Mbaud at 100 MHz); the bench transmitter uses the same divider.
RAM_WAIT, 2, cycles WE/OE held low per SRAM access (min 1).

Ports:
clk  in  1  system clock, 100 MHz
greset  in  1  reset, asynchronous, active-high
B1  in  1  dump button, active-low, asynchronous (2-FF synchronised)
UART_RX  in  1  serial input, idle high (2-FF synchronised)
UART_TX  out  1  serial output, idle high
RAMCS  out  1  SRAM chip select, active-low
RAMWE  out  1  SRAM write enable, active-low
RAMOE  out  1  SRAM output enable, active-low
RAMLB  out  1  low-byte lane enable, active-low
RAMUB  out  1  high-byte lane enable, active-low
ADR  out  18  SRAM word address
DAT  inout  16  SRAM data; driven only during write states, else high-Z

Behaviour:
- Interface: one clock (clk); reset greset is asynchronous and active-high. All flops clear on greset assertion.
- Reset values:
  - RAMCS/RAMWE/RAMOE/RAMLB/RAMUB=1, ADR=0, DAT=Z, UART_TX=1.
  - wr_ptr=0, FSM=IDLE.
- UART RX:
  - Start detected on synchronised falling edge; start bit re-checked at BAUD_DIV/2.
  - Data sampled every BAUD_DIV, LSB first.
  - Stop bit must be 1, else frame discarded.
  - On success, 1-cycle rx_valid with rx_data[7:0].
- UART TX: tx_req/tx_ready/tx_data.
  - tx_ready high when idle; byte latched on tx_req&tx_ready.
  - Frame: start, 8 data LSB first, stop, each BAUD_DIV cycles.
- FSM states and sequence:
  - IDLE -> WR_SETUP -> WR_PULSE -> WR_HOLD -> RD_PULSE -> RD_SAMPLE -> TX_WAIT -> IDLE.
- Write path:
  - In IDLE, rx_valid latches the byte; ADR=wr_ptr.
  - WR_SETUP: RAMCS=0, RAMLB=0, RAMUB=1; DAT={8'h00,byte}, WE=1.
  - WR_PULSE: RAMWE=0 for RAM_WAIT cycles.
  - WR_HOLD: WE=1, data still driven, 1 cycle; then DAT released.
- Read path:
  - RD_PULSE: RAMCS=0, RAMOE=0, RAMLB=0 for RAM_WAIT cycles.
  - RD_SAMPLE: DAT[7:0] captured on the last OE-low cycle; OE/CS deassert.
- TX_WAIT: assert tx_req with the captured byte until accepted, then wr_ptr+=1 (wraps 0x3FFFF->0).
- Never: WE and OE low simultaneously; DAT driven while OE low.
- Bytes received while not IDLE are dropped; no queue.
- Dump:
  - Synchronised B1 falling edge in IDLE starts dump; ignored if not IDLE.
  - Reads addresses 0..wr_ptr-1 and transmits each low byte.
  - wr_ptr=0 means no output.
  - RX bytes are dropped during dump.
- Reset mid-access: outputs return to idle values immediately (async), DAT high-Z.

Optional Feature:
SRAM_VERIFY_EN
- Defined: readback low byte is compared to the written byte. Match transmits the byte; mismatch transmits 0x21 ('!').
- Not defined: readback byte is transmitted unconditionally.
- Dump mode never verifies.

Decomposition:
- Package sram_uart_pkg holds:
  - FSM state enum;
  - idle-value constants for the SRAM strobes;
  - ADDR_W=18, DATA_W=16.
- Natural sub-module: sram_uart_rx (receiver with synchroniser).
- The transmitter reuses the existing uart_tx block: ports clk, reset_ (active-low, driven !greset), tx_req, tx_ready, tx_data, uart_tx.

Test Plan:
- Reset: hold greset 10 cycles -> all strobes 1, DAT=Z, UART_TX=1 throughout.
- Single byte: bench SRAM model returns ADR on read; send 'H' (0x48) -> one write at ADR=0 with DAT=0x0048, WE pulse RAM_WAIT cycles; readback transmitted = 0x00 ('!' with SRAM_VERIFY_EN).
- Back-to-back: send "H","e" -> writes at ADR 0 and 1; TX bytes 0x00, 0x01; wr_ptr=2.
- Bus safety: assertion every cycle -> never (!RAMWE && !RAMOE); DAT driven only in write states.
- Dump: after two bytes, pulse B1 low -> reads ADR 0,1; TX 0x00, 0x01; B1 pulse with wr_ptr=0 -> no TX.
- Robustness:
  - Frame with stop bit 0 -> no SRAM access.
  - greset mid-WR_PULSE -> RAMWE=1 and DAT=Z the same cycle.
